sme_feeder: RTL and testbench
=============================

Name: sme_feeder

Overview:
- Host-side transmitter for the string-matching engine's byte-serial input (chardata/isstring/ispattern) and collector of its result (valid/match/match_index).
- Holds one string (up to 32 chars) and up to NPAT patterns (up to 8 chars each), loaded by a host through a simple write port.
- On start, streams the string followed by one pattern, waits for the engine's result, and records it; repeats for every configured pattern.
- Drives and samples the engine from the same clock domain.

Parameters:
- NPAT, 4, number of pattern slots (power of 2, 2..16); PSW = log2(NPAT)
- TIMEOUT, 256, cycles allowed in WAIT before the result is declared lost (8..65535)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- str_we  in  1  write wdata into string slot str_waddr
- str_waddr  in  5  string char index 0..31
- pat_we  in  1  write wdata into pattern pat_sel, char pat_waddr
- pat_sel  in  PSW  pattern slot select (also used by plen_we)
- pat_waddr  in  3  pattern char index 0..7
- wdata  in  8  load data
- plen_we  in  1  write plen_data into length register of slot pat_sel
- plen_data  in  3  pattern length minus 1 (1..8 chars)
- str_len_m1  in  5  string length minus 1 (1..32 chars), sampled on start
- pat_num_m1  in  PSW  number of patterns minus 1, sampled on start
- start  in  1  one-cycle run request; ignored while busy
- chardata  out  8  byte to engine
- isstring  out  1  chardata is a string char
- ispattern  out  1  chardata is a pattern char
- valid  in  1  engine result strobe
- match  in  1  engine match flag, qualified by valid
- match_index  in  5  engine match position, qualified by valid
- res_valid  out  1  one-cycle pulse: result fields updated
- res_pat  out  PSW  pattern slot the result belongs to
- res_match  out  1  captured match (0 on timeout)
- res_index  out  5  captured match_index (0 on timeout or no match)
- res_timeout  out  1  result lost, TIMEOUT expired
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset, asynchronous, active-low: FSM to IDLE; all outputs 0; counters 0. Buffers need not be cleared.
- Reset asserted mid-run: isstring/ispattern drop immediately; no res_valid or done is emitted.
- Loads:
  - str_we, pat_we and plen_we are accepted in any state.
  - Writes during busy take effect, but content or lengths already sampled or sent in the current run are not guaranteed.
- All engine-facing outputs are registered. chardata is 0 whenever isstring and ispattern are both 0.
- FSM states: IDLE, SEND_STR, SEND_PAT, WAIT, GAP, DONE.
  - IDLE: start=1 latches str_len_m1 and pat_num_m1, sets p=0, char counter=0, goes to SEND_STR.
  - SEND_STR:
    - isstring=1, chardata=str[cnt] for exactly str_len_m1+1 consecutive cycles.
    - After the last char, goes to SEND_PAT with no gap; ispattern rises in the cycle isstring falls.
  - SEND_PAT:
    - ispattern=1, chardata=pat[p][cnt] for plen[p]+1 consecutive cycles.
    - Then goes to WAIT with the timeout counter cleared.
  - WAIT:
    - Outputs idle.
    - valid=1: capture match and match_index, pulse res_valid next cycle with res_pat=p, res_timeout=0, go to GAP.
    - Timeout counter reaching TIMEOUT-1 without valid: res_valid pulse with res_match=0, res_index=0, res_timeout=1, go to GAP.
    - valid is counted from the first WAIT cycle; valid coinciding with the terminal count wins over timeout.
  - GAP:
    - Exactly one idle cycle, giving the engine a clean return to idle.
    - If p==pat_num_m1 go to DONE; else p++, cnt=0, go to SEND_STR. The string is resent before every pattern.
  - DONE: done=1 for one cycle; busy falls the same cycle; go to IDLE.
- valid outside WAIT is ignored.
- start while busy is ignored; start in the DONE cycle is ignored.
- Result fields hold their last values between res_valid pulses.
- Cycle count per pattern without timeout: (str_len_m1+1) + (plen+1) + engine latency + 2.

Test Plan:
- String "ab c" (str_len_m1=3), 1 pattern "c" (plen=0), engine model returns valid with match=1, index=3 after 5 cycles. Required:
  - isstring high 4 cycles with 0x61,0x62,0x20,0x63.
  - ispattern high 1 cycle with 0x63 in the very next cycle.
  - res_valid with res_pat=0, res_match=1, res_index=3.
  - done one cycle later than GAP.
- 4 patterns (pat_num_m1=3), lengths 1,8,3,2 -> string resent 4 times; res_pat sequences 0,1,2,3; exactly 4 res_valid and 1 done.
- Engine never asserts valid, TIMEOUT=8 -> res_valid 8 cycles after WAIT entry with res_timeout=1, res_match=0, res_index=0; run continues to next pattern.
- Maximum sizes: str_len_m1=31, plen=7 -> 32 string bytes then 8 pattern bytes, contiguous, correct order, chardata=0 afterward.
- start pulsed again during SEND_PAT, and valid pulsed during SEND_STR -> both ignored; results unchanged from the single-run expectation.
- reset driven low during WAIT -> isstring, ispattern, busy, res_valid and done all 0 asynchronously. After release with start, the run restarts from pattern 0.

Source files
------------

// File: rtl/sme_feeder.sv
// Host-side feeder for the string-matching engine: streams a stored string plus each
// stored pattern over the byte-serial engine port and collects one result per pattern.
module sme_feeder #(
    parameter int NPAT    = 4,
    parameter int TIMEOUT = 256,
    localparam int PSW    = $clog2(NPAT)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           str_we,
    input  logic [4:0]     str_waddr,
    input  logic           pat_we,
    input  logic [PSW-1:0] pat_sel,
    input  logic [2:0]     pat_waddr,
    input  logic [7:0]     wdata,
    input  logic           plen_we,
    input  logic [2:0]     plen_data,
    input  logic [4:0]     str_len_m1,
    input  logic [PSW-1:0] pat_num_m1,
    input  logic           start,
    output logic [7:0]     chardata,
    output logic           isstring,
    output logic           ispattern,
    input  logic           valid,
    input  logic           match,
    input  logic [4:0]     match_index,
    output logic           res_valid,
    output logic [PSW-1:0] res_pat,
    output logic           res_match,
    output logic [4:0]     res_index,
    output logic           res_timeout,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, GAP, DONE} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [7:0] str_mem  [32];
    logic [7:0] pat_mem  [NPAT*8];
    logic [2:0] plen_mem [NPAT];

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [PSW-1:0] p_q, p_d;
    logic [4:0]     slen_q, slen_d;
    logic [PSW-1:0] pnum_q, pnum_d;
    logic [15:0]    tmo_q, tmo_d;
    logic [7:0]     chardata_q, chardata_d;
    logic           isstring_q, isstring_d;
    logic           ispattern_q, ispattern_d;
    logic           res_valid_q, res_valid_d;
    logic [PSW-1:0] res_pat_q, res_pat_d;
    logic           res_match_q, res_match_d;
    logic [4:0]     res_index_q, res_index_d;
    logic           res_timeout_q, res_timeout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Buffers are plain storage and are never reset.
    always_ff @(posedge clk) begin
        if (str_we)  str_mem[str_waddr]           <= wdata;
        if (pat_we)  pat_mem[{pat_sel, pat_waddr}] <= wdata;
        if (plen_we) plen_mem[pat_sel]            <= plen_data;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        p_d           = p_q;
        slen_d        = slen_q;
        pnum_d        = pnum_q;
        tmo_d         = tmo_q;
        res_valid_d   = 1'b0;
        res_pat_d     = res_pat_q;
        res_match_d   = res_match_q;
        res_index_d   = res_index_q;
        res_timeout_d = res_timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    slen_d  = str_len_m1;
                    pnum_d  = pat_num_m1;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = SEND_STR;
                end
            end
            SEND_STR: begin
                if (cnt_q == slen_q) begin
                    cnt_d   = '0;
                    state_d = SEND_PAT;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            SEND_PAT: begin
                if (cnt_q[2:0] == plen_mem[p_q]) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            WAIT: begin
                // A result arriving on the terminal count still counts as a result.
                if (valid) begin
                    res_valid_d   = 1'b1;
                    res_pat_d     = p_q;
                    res_match_d   = match;
                    res_index_d   = match ? match_index : 5'd0;
                    res_timeout_d = 1'b0;
                    state_d       = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    res_valid_d   = 1'b1;
                    res_pat_d     = p_q;
                    res_match_d   = 1'b0;
                    res_index_d   = 5'd0;
                    res_timeout_d = 1'b1;
                    state_d       = GAP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            GAP: begin
                if (p_q == pnum_q) begin
                    state_d = DONE;
                end else begin
                    p_d     = p_q + 1'b1;
                    cnt_d   = '0;
                    state_d = SEND_STR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Engine-facing outputs are decoded from the next state so they leave a flop.
        isstring_d  = (state_d == SEND_STR);
        ispattern_d = (state_d == SEND_PAT);
        chardata_d  = 8'd0;
        if (isstring_d)
            chardata_d = str_mem[cnt_d];
        else if (ispattern_d)
            chardata_d = pat_mem[{p_d, cnt_d[2:0]}];
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            p_q           <= '0;
            slen_q        <= '0;
            pnum_q        <= '0;
            tmo_q         <= '0;
            chardata_q    <= '0;
            isstring_q    <= 1'b0;
            ispattern_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_pat_q     <= '0;
            res_match_q   <= 1'b0;
            res_index_q   <= '0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            p_q           <= p_d;
            slen_q        <= slen_d;
            pnum_q        <= pnum_d;
            tmo_q         <= tmo_d;
            chardata_q    <= chardata_d;
            isstring_q    <= isstring_d;
            ispattern_q   <= ispattern_d;
            res_valid_q   <= res_valid_d;
            res_pat_q     <= res_pat_d;
            res_match_q   <= res_match_d;
            res_index_q   <= res_index_d;
            res_timeout_q <= res_timeout_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign chardata    = chardata_q;
    assign isstring    = isstring_q;
    assign ispattern   = ispattern_q;
    assign res_valid   = res_valid_q;
    assign res_pat     = res_pat_q;
    assign res_match   = res_match_q;
    assign res_index   = res_index_q;
    assign res_timeout = res_timeout_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: a small engine model answers each pattern, and a
// scoreboard holds the expected byte stream and result records.
module tb_sme_feeder;

    localparam int ENG_LAT = 5;
    localparam int TMO     = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       str_we, pat_we, plen_we, start;
    logic [4:0] str_waddr, str_len_m1;
    logic [1:0] pat_sel, pat_num_m1;
    logic [2:0] pat_waddr, plen_data;
    logic [7:0] wdata;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       valid, match;
    logic [4:0] match_index;
    logic       res_valid, res_match, res_timeout, busy, done;
    logic [1:0] res_pat;
    logic [4:0] res_index;

    sme_feeder #(.NPAT(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .str_we(str_we), .str_waddr(str_waddr),
        .pat_we(pat_we), .pat_sel(pat_sel), .pat_waddr(pat_waddr), .wdata(wdata),
        .plen_we(plen_we), .plen_data(plen_data),
        .str_len_m1(str_len_m1), .pat_num_m1(pat_num_m1), .start(start),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .valid(valid), .match(match), .match_index(match_index),
        .res_valid(res_valid), .res_pat(res_pat), .res_match(res_match),
        .res_index(res_index), .res_timeout(res_timeout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [9:0]  sq [$];
    logic [31:0] rq [$];

    logic [7:0] str_m [32];
    logic [7:0] pat_m [4][8];
    int         plen_m [4];

    bit         eng_on    = 1'b1;
    bit         spur_req  = 1'b0;
    logic       eng_mbase = 1'b0;
    logic [4:0] eng_idx   = 5'd0;
    logic [4:0] eng_k     = 5'd0;

    int done_cnt = 0;
    int res_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Engine model: answers ENG_LAT cycles into WAIT, and can inject a stray strobe.
    initial begin : engine
        bit eprev;
        eprev = 1'b0;
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
        forever begin
            @(negedge clk);
            valid = 1'b0; match = 1'b0; match_index = 5'd0;
            if (spur_req && isstring) begin
                valid = 1'b1; match = 1'b1; match_index = 5'd31;
                spur_req = 1'b0;
            end else if (eprev && !ispattern && reset && eng_on) begin
                repeat (ENG_LAT - 1) @(negedge clk);
                valid = 1'b1;
                match = eng_k[0] ^ eng_mbase;
                match_index = eng_idx + eng_k;
                eng_k = eng_k + 5'd1;
            end
            eprev = ispattern;
        end
    end

    // Output monitor: checks the stream, idle data, results and done placement.
    initial begin : monitor
        bit prev_is, prev_ip, prev_rv;
        int wcnt;
        logic [31:0] e, o;
        prev_is = 0; prev_ip = 0; prev_rv = 0; wcnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (prev_ip && !ispattern) wcnt = 0;
                else if (wcnt < 255) wcnt++;
                if (isstring || ispattern) begin
                    if (sq.size() == 0) chk("stream_extra", {22'd0, isstring, ispattern, chardata}, 32'd0);
                    else chk("stream", {22'd0, isstring, ispattern, chardata}, {22'd0, sq.pop_front()});
                end else begin
                    chk("idle_chardata", {24'd0, chardata}, 32'd0);
                end
                if (prev_is && !isstring) chk("str_to_pat", {31'd0, ispattern}, 32'd1);
                if (res_valid) begin
                    res_cnt++;
                    o = {8'(wcnt), 6'd0, res_pat, 7'd0, res_match, res_timeout, 2'd0, res_index};
                    if (rq.size() == 0) chk("result_extra", o, 32'd0);
                    else begin
                        e = rq.pop_front();
                        chk("result", o, e);
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("done_after_gap", {31'd0, prev_rv}, 32'd1);
                    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
                end
            end
            prev_is = isstring; prev_ip = ispattern; prev_rv = res_valid;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    task automatic wstr(input int i, input logic [7:0] d);
        str_we = 1'b1; str_waddr = 5'(i); wdata = d; str_m[i] = d;
        @(negedge clk);
        str_we = 1'b0;
    endtask

    task automatic wpat(input int s, input int i, input logic [7:0] d);
        pat_we = 1'b1; pat_sel = 2'(s); pat_waddr = 3'(i); wdata = d; pat_m[s][i] = d;
        @(negedge clk);
        pat_we = 1'b0;
    endtask

    task automatic wplen(input int s, input int l_m1);
        plen_we = 1'b1; pat_sel = 2'(s); plen_data = 3'(l_m1); plen_m[s] = l_m1;
        @(negedge clk);
        plen_we = 1'b0;
    endtask

    task automatic run(input int slen, input int pnum, input bit eng);
        logic       m;
        logic [4:0] idx;
        for (int j = 0; j <= pnum; j++) begin
            for (int i = 0; i <= slen; i++) sq.push_back({2'b10, str_m[i]});
            for (int i = 0; i <= plen_m[j]; i++) sq.push_back({2'b01, pat_m[j][i]});
            m   = eng ? (1'(j) ^ eng_mbase) : 1'b0;
            idx = m ? 5'(eng_idx + 5'(j)) : 5'd0;
            rq.push_back({8'(eng ? ENG_LAT : TMO), 8'(j), 7'd0, m, !eng, 2'd0, idx});
        end
        eng_on = eng; eng_k = 5'd0;
        str_len_m1 = 5'(slen); pat_num_m1 = 2'(pnum);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("run_done", {31'd0, done}, 32'd1);
    endtask

    task automatic finish_run(input int d0, input int r0, input int nres);
        @(negedge clk);
        chk("done_count", done_cnt - d0, 1);
        chk("res_count", res_cnt - r0, nres);
        chk("stream_left", sq.size(), 0);
        chk("result_left", rq.size(), 0);
    endtask

    task automatic load_abc();
        wstr(0, 8'h61); wstr(1, 8'h62); wstr(2, 8'h20); wstr(3, 8'h63);
        wpat(0, 0, 8'h63); wplen(0, 0);
    endtask

    initial begin : main
        int d0, r0, n;
        reset = 1'b0;
        str_we = 0; pat_we = 0; plen_we = 0; start = 0;
        str_waddr = 0; pat_sel = 0; pat_waddr = 0; wdata = 0; plen_data = 0;
        str_len_m1 = 0; pat_num_m1 = 0;
        #12;
        chk("rst_isstring", {31'd0, isstring}, 32'd0);
        chk("rst_ispattern", {31'd0, ispattern}, 32'd0);
        chk("rst_chardata", {24'd0, chardata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", {22'd0, res_valid, res_pat, res_match, res_index, res_timeout}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // "ab c" against "c", then a start in the DONE cycle
        load_abc();
        eng_mbase = 1'b1; eng_idx = 5'd3;
        d0 = done_cnt; r0 = res_cnt;
        run(3, 0, 1'b1);
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_count", done_cnt - d0, 1);
        chk("res_count", res_cnt - r0, 1);
        repeat (3) @(negedge clk);
        chk("start_in_done_ignored", {31'd0, busy}, 32'd0);

        // four patterns, string resent each time
        wstr(0, 8'h68); wstr(1, 8'h65); wstr(2, 8'h6c); wstr(3, 8'h6c); wstr(4, 8'h6f);
        wpat(0, 0, 8'h6c); wplen(0, 0);
        for (int i = 0; i < 8; i++) wpat(1, i, 8'(8'h41 + i));
        wplen(1, 7);
        wpat(2, 0, 8'h65); wpat(2, 1, 8'h6c); wpat(2, 2, 8'h6c); wplen(2, 2);
        wpat(3, 0, 8'h6c); wpat(3, 1, 8'h6f); wplen(3, 1);
        eng_mbase = 1'b0; eng_idx = 5'd10;
        d0 = done_cnt; r0 = res_cnt;
        run(4, 3, 1'b1);
        wait_done();
        finish_run(d0, r0, 4);

        // silent engine: timeout on both patterns
        d0 = done_cnt; r0 = res_cnt;
        run(4, 1, 1'b0);
        wait_done();
        finish_run(d0, r0, 2);

        // maximum string and pattern lengths
        for (int i = 0; i < 32; i++) wstr(i, 8'(8'h30 + 7 * i));
        for (int i = 0; i < 8; i++) wpat(0, i, 8'(8'ha0 + i));
        wplen(0, 7);
        eng_mbase = 1'b1; eng_idx = 5'd31;
        d0 = done_cnt; r0 = res_cnt;
        run(31, 0, 1'b1);
        wait_done();
        finish_run(d0, r0, 1);

        // stray valid during SEND_STR and a second start during SEND_PAT
        load_abc();
        eng_mbase = 1'b1; eng_idx = 5'd3;
        spur_req = 1'b1;
        d0 = done_cnt; r0 = res_cnt;
        run(3, 0, 1'b1);
        n = 0;
        while (!ispattern && n < 50) begin @(negedge clk); n++; end
        chk("saw_ispattern", {31'd0, ispattern}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        finish_run(d0, r0, 1);
        repeat (3) @(negedge clk);
        chk("no_rerun", {31'd0, busy}, 32'd0);

        // reset while waiting for the engine, then a clean rerun
        wpat(1, 0, 8'h62); wplen(1, 0);
        run(3, 1, 1'b1);
        n = 0;
        while (!ispattern && n < 50) begin @(negedge clk); n++; end
        while (ispattern && n < 60) begin @(negedge clk); n++; end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_isstring", {31'd0, isstring}, 32'd0);
        chk("arst_ispattern", {31'd0, ispattern}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        sq.delete();
        rq.delete();
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, isstring}, 32'd0);
        d0 = done_cnt; r0 = res_cnt;
        run(3, 1, 1'b1);
        wait_done();
        finish_run(d0, r0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
